// File: rtl/pulse_sequencer.sv
// Programmable pulse sequencer: steps through a table of tick periods and
// emits a one-cycle pulse at the end of each step. The table can be repeated
// for several passes, and a running sequence can be aborted.
module pulse_sequencer #(
   parameter int N     = 8,
   parameter int STEPS = 4,
   localparam int S    = (STEPS > 1) ? $clog2(STEPS) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         cfg_we,
   input  logic [S-1:0] cfg_addr,
   input  logic [N-1:0] cfg_data,
   input  logic [7:0]   repeat_count,
   input  logic         start,
   input  logic         stop,
   output logic         out,
   output logic [S-1:0] step_idx,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state_q;
   logic [N-1:0] tbl_q [STEPS];
   logic [N-1:0] cnt_q;
   logic [S-1:0] step_q;
   logic [7:0]   pass_q;
   logic [7:0]   rep_q;
   logic         out_q;

   logic [S-1:0] step_d;
   logic [N-1:0] per_m1;
   logic         pass_end;
   logic         addr_ok;

   // Decode of the current step: terminal count, following index, pass end.
   // The wrapped step_d at the last entry is never used because the
   // STEPS-1 test already flags the pass end.
   always_comb begin
      step_d   = step_q + S'(1);
      per_m1   = tbl_q[step_q] - N'(1);
      pass_end = (int'(step_q) == STEPS - 1) || (tbl_q[step_d] == '0);
      addr_ok  = (int'(cfg_addr) < STEPS);
   end

   // Sequencer FSM with period table, counters and registered pulse output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         pass_q  <= '0;
         rep_q   <= '0;
         out_q   <= 1'b0;
         for (int i = 0; i < STEPS; i++) tbl_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               out_q <= 1'b0;
               // Table write and start share an edge: start sees the old
               // entry 0 because both read/write through non-blocking state.
               if (cfg_we && addr_ok) tbl_q[cfg_addr] <= cfg_data;
               if (start) begin
                  if (tbl_q[0] != '0) begin
                     cnt_q   <= '0;
                     step_q  <= '0;
                     pass_q  <= '0;
                     rep_q   <= repeat_count;
                     state_q <= RUN;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  // Abort wins over a coinciding step end: no pulse, no done.
                  state_q <= IDLE;
                  out_q   <= 1'b0;
                  cnt_q   <= '0;
                  step_q  <= '0;
                  pass_q  <= '0;
               end else if (!ena) begin
                  out_q <= 1'b0;
               end else if (cnt_q != per_m1) begin
                  cnt_q <= cnt_q + N'(1);
                  out_q <= 1'b0;
               end else begin
                  out_q <= 1'b1;
                  cnt_q <= '0;
                  if (!pass_end) begin
                     step_q <= step_d;
                  end else if (pass_q != rep_q) begin
                     pass_q <= pass_q + 8'd1;
                     step_q <= '0;
                  end else begin
                     state_q <= DONE;
                     step_q  <= '0;
                     pass_q  <= '0;
                  end
               end
            end
            DONE: begin
               out_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               out_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out      = out_q;
   assign step_idx = step_q;
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed testbench for pulse_sequencer (N=8, STEPS=4).
module tb_pulse_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic [7:0] repeat_count = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       out;
   logic [1:0] step_idx;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   pulse_sequencer #(.N(8), .STEPS(4)) dut (
      .clk(clk), .rst(rst), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .repeat_count(repeat_count), .start(start),
      .stop(stop), .out(out), .step_idx(step_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      cfg_we   = 1'b1;
      cfg_addr = a[1:0];
      cfg_data = d[7:0];
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic clear_table;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({out, busy, done, step_idx} !== 5'b00000) begin
         errors++;
         $display("FAIL reset out/busy/done/step=%b%b%b%0d expected 0000", out, busy, done, step_idx);
      end
      rst = 1'b0;
   endtask

   task automatic test_timing;
      logic eo, ed, eb;
      logic [1:0] es;
      clear_table();
      wr(0, 3); wr(1, 5); wr(2, 0);
      repeat_count = 8'd0;
      ena = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, out, done, step_idx} !== 5'b10000) begin
         errors++;
         $display("FAIL timing_start busy/out/done/step=%b%b%b%0d expected 1000", busy, out, done, step_idx);
      end
      for (int k = 1; k <= 9; k++) begin
         tick();
         eo = (k == 3 || k == 8);
         ed = (k == 8);
         eb = (k < 8);
         es = (k >= 3 && k < 8) ? 2'd1 : 2'd0;
         checks++;
         if ({out, done, busy} !== {eo, ed, eb}) begin
            errors++;
            $display("FAIL timing k=%0d out/done/busy=%b%b%b expected %b%b%b", k, out, done, busy, eo, ed, eb);
         end
         checks++;
         if (step_idx !== es) begin
            errors++;
            $display("FAIL timing_step k=%0d step_idx=%0d expected %0d", k, step_idx, es);
         end
      end
   endtask

   task automatic test_repeat;
      int npulse;
      int ndone;
      logic eo, ed;
      logic [1:0] es;
      npulse = 0;
      ndone  = 0;
      clear_table();
      for (int i = 0; i < 4; i++) wr(i, 2);
      repeat_count = 8'd2;
      ena = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 26; k++) begin
         tick();
         eo = (k % 2 == 0) && (k <= 24);
         ed = (k == 24);
         es = (k < 24) ? 2'((k / 2) % 4) : 2'd0;
         if (out === 1'b1) npulse++;
         if (done === 1'b1) ndone++;
         checks++;
         if ({out, done} !== {eo, ed} || step_idx !== es) begin
            errors++;
            $display("FAIL repeat k=%0d out/done/step=%b%b%0d expected %b%b%0d", k, out, done, step_idx, eo, ed, es);
         end
      end
      checks++;
      if (npulse != 12 || ndone != 1) begin
         errors++;
         $display("FAIL repeat_totals pulses=%0d dones=%0d expected 12 1", npulse, ndone);
      end
      repeat_count = 8'd0;
   endtask

   task automatic test_gating;
      logic eo;
      clear_table();
      wr(0, 4);
      ena = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         ena = (k % 2 == 1);
         tick();
         eo = (k == 7);
         checks++;
         if ({out, done} !== {eo, eo}) begin
            errors++;
            $display("FAIL gating k=%0d out/done=%b%b expected %b%b", k, out, done, eo, eo);
         end
      end
      ena = 1'b1;
   endtask

   task automatic test_stop;
      clear_table();
      wr(0, 3); wr(1, 5);
      ena = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({out, busy, done, step_idx} !== 5'b00000) begin
         errors++;
         $display("FAIL stop out/busy/done/step=%b%b%b%0d expected 0000", out, busy, done, step_idx);
      end
      tick();
      checks++;
      if ({out, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL stop_after out/busy/done=%b%b%b expected 000", out, busy, done);
      end
   endtask

   task automatic test_zero;
      clear_table();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({done, out, busy} !== 3'b100) begin
         errors++;
         $display("FAIL zero done/out/busy=%b%b%b expected 100", done, out, busy);
      end
      tick();
      checks++;
      if ({done, out, busy} !== 3'b000) begin
         errors++;
         $display("FAIL zero_after done/out/busy=%b%b%b expected 000", done, out, busy);
      end
   endtask

   task automatic test_locked;
      clear_table();
      wr(0, 3);
      ena = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd7;
      tick();
      cfg_we = 1'b0;
      tick();
      tick();
      checks++;
      if ({out, done} !== 2'b11) begin
         errors++;
         $display("FAIL locked_run1 out/done=%b%b expected 11", out, done);
      end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL locked_run2_early out=%b expected 0", out);
      end
      tick();
      checks++;
      if ({out, done} !== 2'b11) begin
         errors++;
         $display("FAIL locked_run2 out/done=%b%b expected 11", out, done);
      end
      tick();
   endtask

   task automatic test_collision;
      clear_table();
      ena = 1'b1;
      start = 1'b1;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd2;
      tick();
      start = 1'b0;
      cfg_we = 1'b0;
      checks++;
      if ({done, busy, out} !== 3'b100) begin
         errors++;
         $display("FAIL collision done/busy/out=%b%b%b expected 100", done, busy, out);
      end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL collision_restart busy=%b expected 1", busy);
      end
      tick();
      tick();
      checks++;
      if ({out, done} !== 2'b11) begin
         errors++;
         $display("FAIL collision_pulse out/done=%b%b expected 11", out, done);
      end
      tick();
   endtask

   task automatic test_reset_mid_run;
      clear_table();
      wr(0, 5);
      ena = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({out, busy, done, step_idx} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid out/busy/done/step=%b%b%b%0d expected 0000", out, busy, done, step_idx);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({done, out, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_mid_restart done/out/busy=%b%b%b expected 100", done, out, busy);
      end
      tick();
      checks++;
      if ({done, out, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_idle done/out/busy=%b%b%b expected 000", done, out, busy);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_repeat();
      test_gating();
      test_stop();
      test_zero();
      test_locked();
      test_collision();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameter N, default 8, width of period entries and tick counter.
REQ-002 Parameter STEPS, default 4, number of period table entries; index width S = clog2(STEPS).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  tick enable; counter advances only on edges where ena=1.
REQ-006 cfg_we  input  1  period table write strobe.
REQ-007 cfg_addr  input  S  table entry index for write.
REQ-008 cfg_data  input  N  period value for write.
REQ-009 repeat_count  input  8  extra passes through the table (0 = one pass), latched at start.
REQ-010 start  input  1  begin sequence, level sampled per edge.
REQ-011 stop  input  1  abort running sequence.
REQ-012 out  output  1  registered one-cycle pulse per completed step.
REQ-013 step_idx  output  S  index of step currently timing.
REQ-014 busy  output  1  high while state is RUN.
REQ-015 done  output  1  high exactly one cycle when a sequence finishes normally.

Function
REQ-016 FSM states IDLE, RUN, DONE; busy=(state==RUN), done=(state==DONE).
REQ-017 IDLE: cfg_we=1 writes cfg_data to table[cfg_addr] at the edge; cfg_addr >= STEPS is ignored.
REQ-018 In RUN or DONE, cfg_we is ignored; the table is locked.
REQ-019 IDLE with start=1 and table[0]!=0: counter<=0, step<=0, pass<=0, latch repeat_count, go RUN.
REQ-020 IDLE with start=1 and table[0]==0: go DONE directly; no pulse is emitted.
REQ-021 If start and cfg_we are both high in IDLE, the write takes effect and start uses the pre-write table contents.
REQ-022 In RUN, start is ignored.
REQ-023 RUN edge with ena=0: counter, step and pass hold; out<=0.
REQ-024 RUN edge with ena=1 and counter != table[step]-1: counter<=counter+1; out<=0.
REQ-025 RUN edge with ena=1 and counter == table[step]-1: out<=1, counter<=0, step ends.
REQ-026 Pass end: the step that ends is STEPS-1, or table[step+1]==0.
REQ-027 Step end, not pass end: step<=step+1.
REQ-028 Pass end with pass < latched repeat_count: pass<=pass+1, step<=0.
REQ-029 Pass end with pass == latched repeat_count: go DONE.
REQ-030 Period P therefore gives out high in the cycle after the P-th enabled edge of the step, counted from the start edge or the previous step end.
REQ-031 With ena held high, consecutive pulses of a step sequence are spaced by the step periods exactly, with no gap cycles.
REQ-032 DONE lasts one cycle, then the FSM goes to IDLE; out<=0 in DONE.
REQ-033 stop=1 in RUN: next state IDLE, out<=0, counter<=0, done is not asserted.
REQ-034 stop overrides a step end on the same edge, so no pulse is emitted.
REQ-035 stop is ignored in IDLE and DONE.
REQ-036 Period arithmetic is unsigned N-bit; the maximum period is 2^N-1.
REQ-037 The pass counter is 8 bits, allowing up to 256 total passes.
REQ-038 step_idx reflects the step register; it is 0 in IDLE.

Reset
REQ-039 rst=1 at an edge forces: state IDLE, counter 0, step 0, pass 0, out 0, busy 0, done 0.
REQ-040 rst=1 at an edge clears all table entries to 0.
REQ-041 rst has priority over all other inputs, and reset mid-RUN aborts the sequence without a done pulse.

Verification
REQ-042 Pulse timing: table={3,5,0,x}, repeat_count=0, ena=1, start pulsed at edge E -> out high after E+3 and E+8, then done high in the cycle after the E+8 edge, then IDLE.
REQ-043 Repeat and full table: table={2,2,2,2}, repeat_count=2 -> 12 pulses spaced 2 cycles apart; step_idx cycles 0..3 three times; done once.
REQ-044 Enable gating: table={4,0,..}, ena toggling 1,0,1,0,... -> single pulse after the 4th enabled edge (8 cycles); out is never high on an ena=0 edge.
REQ-045 Stop collision: stop asserted on the same edge as a step end -> no out pulse, no done, next cycle IDLE with busy=0.
REQ-046 Zero and illegal input: start with table[0]=0 -> done after one cycle, no out. Also, cfg_we during RUN leaves the table unchanged on readback by rerunning.
REQ-047 Reset mid-RUN: rst at counter=2 of period 5 -> all outputs 0 next cycle; a subsequent start with table all 0 gives done with no pulses.
